// File: rtl/game_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : game_cmd_sched
// Description : PS/2 scancode -> game command scheduler with FIFO, fire
//               cooldown and pause ownership.
// Revision    : 1.0
// ============================================================================
module game_cmd_sched #(
    parameter int FIFO_DEPTH    = 4,
    parameter int FIRE_COOLDOWN = 5000000,
    parameter int CD_W          = 23
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] ScanCode,
    input  logic       valid_bit,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    input  logic       cmd_ready,
    output logic       paused,
    output logic [7:0] drop_cnt
);

    localparam int       c_AW     = $clog2(FIFO_DEPTH);
    localparam logic [2:0] c_LEFT   = 3'd0;
    localparam logic [2:0] c_RIGHT  = 3'd1;
    localparam logic [2:0] c_THRUST = 3'd2;
    localparam logic [2:0] c_FIRE   = 3'd3;
    localparam logic [2:0] c_HYPER  = 3'd4;

    logic            r_s1, r_s2, r_s3;
    logic            r_dec;
    logic [7:0]      r_sc;
    logic [c_AW:0]   r_wr, r_rd;
    logic [2:0]      r_mem [FIFO_DEPTH];
    logic [CD_W-1:0] r_cd;
    logic            r_paused;
    logic [7:0]      r_drop;

    logic       w_ev, w_is_cmd, w_is_pause, w_empty, w_full, w_pop;
    logic       w_fire, w_cd_zero, w_accept, w_drop, w_flush;
    logic [2:0] w_code;

    assign w_ev = r_s2 & ~r_s3;

    // Synchronizer, edge detect and scancode capture
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_s3  <= 1'b0;
            r_dec <= 1'b0;
            r_sc  <= 8'h00;
        end else begin
            r_s1  <= valid_bit;
            r_s2  <= r_s1;
            r_s3  <= r_s2;
            r_dec <= w_ev;
            if (w_ev)
                r_sc <= ScanCode;
        end
    end

    always_comb begin
        w_is_cmd   = 1'b0;
        w_is_pause = 1'b0;
        w_code     = c_LEFT;
        case (r_sc)
            8'h1C, 8'h6B: begin w_is_cmd = 1'b1; w_code = c_LEFT;   end
            8'h23, 8'h74: begin w_is_cmd = 1'b1; w_code = c_RIGHT;  end
            8'h1D, 8'h75: begin w_is_cmd = 1'b1; w_code = c_THRUST; end
            8'h29:        begin w_is_cmd = 1'b1; w_code = c_FIRE;   end
            8'h32:        begin w_is_cmd = 1'b1; w_code = c_HYPER;  end
            8'h4D:        w_is_pause = 1'b1;
            default:      ;
        endcase
    end

    assign w_empty   = (r_wr == r_rd);
    assign w_full    = (r_wr[c_AW] != r_rd[c_AW]) && (r_wr[c_AW-1:0] == r_rd[c_AW-1:0]);
    assign w_pop     = ~w_empty & cmd_ready;
    assign w_fire    = (w_code == c_FIRE);
    assign w_cd_zero = (r_cd == '0);
    // A full FIFO still accepts when the head leaves in the same cycle
    assign w_accept  = r_dec & w_is_cmd & ~r_paused & ~(w_fire & ~w_cd_zero) & (~w_full | w_pop);
    assign w_drop    = r_dec & w_is_cmd & ~w_accept;
    assign w_flush   = r_dec & w_is_pause & ~r_paused;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_cd     <= '0;
            r_paused <= 1'b0;
            r_drop   <= 8'h00;
        end else begin
            if (w_flush) begin
                r_rd <= r_wr;
            end else begin
                if (w_accept)
                    r_wr <= r_wr + 1'b1;
                if (w_pop)
                    r_rd <= r_rd + 1'b1;
            end
            if (r_dec && w_is_pause)
                r_paused <= ~r_paused;
            if (w_accept && w_fire)
                r_cd <= CD_W'(FIRE_COOLDOWN);
            else if (!w_cd_zero)
                r_cd <= r_cd - 1'b1;
            if (w_drop && (r_drop != 8'hFF))
                r_drop <= r_drop + 1'b1;
        end
    end

    // Storage needs no reset: reads are masked while empty
    always_ff @(posedge CLK) begin
        if (w_accept)
            r_mem[r_wr[c_AW-1:0]] <= w_code;
    end

    assign cmd_valid = ~w_empty;
    assign cmd_code  = w_empty ? 3'd0 : r_mem[r_rd[c_AW-1:0]];
    assign paused    = r_paused;
    assign drop_cnt  = r_drop;

endmodule
`default_nettype wire
